qwi16_led_ctrl: RTL

Parametrised multi-channel LED controller for the qwi16 Zynq designs. It replaces direct PS-GPIO-to-pin LED wiring. The PS writes per-channel configuration through a simple write port: mode OFF, ON, BLINK or BREATHE, plus a period. The block produces registered LED drive for N_CH pins from a shared tick prescaler and a shared PWM counter. It sits in the top wrapper between the PS GPIO/AXI-GPIO outputs and the board LED pins.

---
 rtl/qwi16_led_pkg.sv | 27 ++
 rtl/qwi16_led_chan.sv | 92 +++++++++
 rtl/qwi16_led_ctrl.sv | 65 ++++++
 3 files changed

// File: rtl/qwi16_led_pkg.sv
// Shared types and constants for the qwi16 LED controller: channel modes,
// breathe ramp direction and the channel-select width helper.
package qwi16_led_pkg;

  localparam logic [1:0] MODE_ENC_OFF     = 2'd0;
  localparam logic [1:0] MODE_ENC_ON      = 2'd1;
  localparam logic [1:0] MODE_ENC_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ENC_BREATHE = 2'd3;

  typedef enum logic [1:0] {
    MODE_OFF     = MODE_ENC_OFF,
    MODE_ON      = MODE_ENC_ON,
    MODE_BLINK   = MODE_ENC_BLINK,
    MODE_BREATHE = MODE_ENC_BREATHE
  } led_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } ramp_dir_t;

  // A single-channel build still needs a 1-bit select port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qwi16_led_chan.sv
// One LED channel: config registers, period counter, blink flop, breathe
// duty ramp and the registered LED output bit.
module qwi16_led_chan
  import qwi16_led_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             wr,
  input  led_mode_t        mode,
  input  logic [PER_W-1:0] period,
  output logic             led
);

  localparam logic [PWM_W-1:0] DUTY_TOP = '1;

  led_mode_t        mode_q;
  logic [PER_W-1:0] period_q;
  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] per_last;
  logic             blink_q;
  logic [PWM_W-1:0] duty;
  ramp_dir_t        dir;
  logic             step;
  logic             led_nxt;

  // A period of 0 behaves as 1, so the last count is clamped at 0.
  assign per_last = (period_q == '0) ? '0 : period_q - PER_W'(1);
  assign step     = tick && (per_cnt == per_last);

  always_comb begin
    led_nxt = 1'b0;
    case (mode_q)
      MODE_ON:      led_nxt = 1'b1;
      MODE_BLINK:   led_nxt = blink_q;
      MODE_BREATHE: led_nxt = (pwm_cnt < duty);
      default:      led_nxt = 1'b0;
    endcase
  end

  // A write in the same cycle as a step event takes priority and
  // discards the step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_OFF;
      period_q <= '0;
      per_cnt  <= '0;
      blink_q  <= 1'b0;
      duty     <= '0;
      dir      <= DIR_UP;
      led      <= 1'b0;
    end else begin
      led <= led_nxt;
      if (wr) begin
        mode_q   <= mode;
        period_q <= period;
        per_cnt  <= '0;
        blink_q  <= 1'b0;
        duty     <= '0;
        dir      <= DIR_UP;
      end else if (step) begin
        per_cnt <= '0;
        if (mode_q == MODE_BLINK) begin
          blink_q <= ~blink_q;
        end
        if (mode_q == MODE_BREATHE) begin
          case (dir)
            DIR_UP: begin
              duty <= duty + PWM_W'(1);
              if (duty == DUTY_TOP - PWM_W'(1)) begin
                dir <= DIR_DOWN;
              end
            end
            default: begin
              duty <= duty - PWM_W'(1);
              if (duty == PWM_W'(1)) begin
                dir <= DIR_UP;
              end
            end
          endcase
        end
      end else if (tick) begin
        per_cnt <= per_cnt + PER_W'(1);
      end
    end
  end

endmodule

// File: rtl/qwi16_led_ctrl.sv
// Multi-channel LED controller: shared tick prescaler and PWM counter,
// configuration write decode, and one qwi16_led_chan per LED pin.
module qwi16_led_ctrl
  import qwi16_led_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = 50000,
  parameter int PER_W    = 16,
  parameter int PWM_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_wr,
  input  logic [ch_width(N_CH)-1:0]     cfg_ch,
  input  logic [1:0]                    cfg_mode,
  input  logic [PER_W-1:0]              cfg_period,
  output logic [N_CH-1:0]               led,
  output logic                          tick
);

  localparam int               PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  logic             wr_ok;
  logic [N_CH-1:0]  ch_wr;
  led_mode_t        wr_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  // cfg_wr is a one-cycle strobe with no ready: every write is accepted,
  // and a write naming a channel that does not exist is silently dropped.
  assign wr_ok   = cfg_wr && (32'(cfg_ch) < 32'(N_CH));
  assign wr_mode = led_mode_t'(cfg_mode);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_wr[i] = wr_ok && (32'(cfg_ch) == 32'(i));

    qwi16_led_chan #(
      .PER_W (PER_W),
      .PWM_W (PWM_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .wr      (ch_wr[i]),
      .mode    (wr_mode),
      .period  (cfg_period),
      .led     (led[i])
    );
  end

endmodule
